quickq_seq: RTL and testbench

//  Sequencer/controller for the QuickQ sorted priority queue held in an external single-port BRAM.

---
 rtl/quickq_seq.sv | 130 +++++++++++++
 tb/tb_quickq_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quickq_seq.sv
// QuickQ sequencer: keeps a descending-sorted priority queue in an external
// single-port BRAM, with a compare/swap walk on insert and a shift walk on removal.
module quickq_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  output logic              enq_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  input  logic              deq_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic [AW-1:0]     bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  typedef enum logic [2:0] {
    IDLE, ENQ_RD, ENQ_CMP, ENQ_TAIL, DEQ_RD, DEQ_WR
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] head;
  logic [AW:0]       idx;
  logic              swap;
  logic              deq_fire;
  logic              enq_fire;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign busy      = (state != IDLE);
  assign deq_valid = (state == IDLE) && !empty;
  assign enq_ready = (state == IDLE) && !full && !(deq_valid && deq_ready);
  assign deq_data  = head;
  assign deq_fire  = deq_valid && deq_ready;
  assign enq_fire  = enq_valid && enq_ready;
  assign swap      = (hold > bram_rdata);

  // BRAM port: read data arrives the cycle after the address, so the
  // swap decision in ENQ_CMP uses the data read during ENQ_RD.
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = hold;
    case (state)
      ENQ_RD: begin
        bram_addr = AW'(idx);
      end
      ENQ_CMP: begin
        bram_addr = AW'(idx);
        bram_we   = swap;
      end
      ENQ_TAIL: begin
        bram_addr = AW'(count);
        bram_we   = 1'b1;
      end
      DEQ_RD: begin
        bram_addr = AW'(idx + (AW+1)'(1));
      end
      DEQ_WR: begin
        bram_addr  = AW'(idx);
        bram_we    = 1'b1;
        bram_wdata = bram_rdata;
      end
      default: begin
        bram_addr = '0;
      end
    endcase
  end

  // Walk control; dequeue has priority over enqueue in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      hold  <= '0;
      head  <= '0;
    end else begin
      if (bram_we && (bram_addr == '0)) head <= bram_wdata;
      case (state)
        IDLE: begin
          if (deq_fire) begin
            if (count == (AW+1)'(1)) begin
              count <= '0;
            end else begin
              idx   <= '0;
              state <= DEQ_RD;
            end
          end else if (enq_fire) begin
            hold  <= enq_data;
            idx   <= '0;
            state <= empty ? ENQ_TAIL : ENQ_RD;
          end
        end
        ENQ_RD: state <= ENQ_CMP;
        ENQ_CMP: begin
          if (swap) hold <= bram_rdata;
          idx   <= idx + (AW+1)'(1);
          state <= (idx == count - (AW+1)'(1)) ? ENQ_TAIL : ENQ_RD;
        end
        ENQ_TAIL: begin
          count <= count + (AW+1)'(1);
          state <= IDLE;
        end
        DEQ_RD: state <= DEQ_WR;
        DEQ_WR: begin
          idx <= idx + (AW+1)'(1);
          if (idx == count - (AW+1)'(2)) begin
            count <= count - (AW+1)'(1);
            state <= IDLE;
          end else begin
            state <= DEQ_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_seq.sv
// Directed bench for quickq_seq with a behavioural 1-cycle-latency BRAM.
module tb_quickq_seq;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enq_valid = 1'b0;
  logic [DATA_W-1:0] enq_data = '0;
  logic              enq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic              deq_ready = 1'b0;
  logic [AW:0]       count;
  logic              full, empty, busy;
  logic [AW-1:0]     bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [AW+DATA_W-1:0] tr [$];
  bit                   tr_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quickq_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
    .count(count), .full(full), .empty(empty), .busy(busy),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
  );

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
    if (tr_en && bram_we) tr.push_back({bram_addr, bram_wdata});
  end

  typedef struct {
    bit          is_enq;
    logic [31:0] data;
    logic [31:0] exp_val;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(output int lat, output int rdy_low);
    lat = 0;
    rdy_low = 0;
    while (busy && lat < 200) begin
      lat++;
      if (!enq_ready) rdy_low++;
      @(negedge clk);
    end
    if (lat >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic do_enq(input logic [31:0] d, output int lat, output int rdy_low);
    int w = 0;
    while (!enq_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) check("enq_ready_timeout", 1, 0);
    enq_valid = 1'b1;
    enq_data  = d;
    @(negedge clk);
    enq_valid = 1'b0;
    wait_idle(lat, rdy_low);
  endtask

  task automatic do_deq(output logic [31:0] v, output int lat);
    int w = 0;
    int rl;
    while (!deq_valid && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) check("deq_valid_timeout", 1, 0);
    v = deq_data;
    deq_ready = 1'b1;
    @(negedge clk);
    deq_ready = 1'b0;
    wait_idle(lat, rl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_tr(input int i, input int a, input logic [31:0] d);
    if (i < tr.size()) check($sformatf("trace[%0d]", i), tr[i], {AW'(a), d});
    else check($sformatf("trace[%0d]_missing", i), 1, 0);
  endtask

  initial begin
    int lat, rl, w;
    logic [31:0] v;

    // test 1, 5 and mixed sequences: {is_enq, data, head-after/dequeued value, count-after}
    vecs[0]  = '{1'b1, 32'd5, 32'd5, 1};
    vecs[1]  = '{1'b1, 32'd9, 32'd9, 2};
    vecs[2]  = '{1'b1, 32'd1, 32'd9, 3};
    vecs[3]  = '{1'b0, 32'd0, 32'd9, 2};
    vecs[4]  = '{1'b0, 32'd0, 32'd5, 1};
    vecs[5]  = '{1'b0, 32'd0, 32'd1, 0};
    vecs[6]  = '{1'b1, 32'd3, 32'd3, 1};
    vecs[7]  = '{1'b1, 32'd3, 32'd3, 2};
    vecs[8]  = '{1'b1, 32'd10, 32'd10, 3};
    vecs[9]  = '{1'b1, 32'd2, 32'd10, 4};
    vecs[10] = '{1'b0, 32'd0, 32'd10, 3};
    vecs[11] = '{1'b0, 32'd0, 32'd3, 2};
    vecs[12] = '{1'b0, 32'd0, 32'd3, 1};
    vecs[13] = '{1'b0, 32'd0, 32'd2, 0};
    vecs[14] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1};
    vecs[15] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[16] = '{1'b0, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[17] = '{1'b0, 32'd0, 32'h0000_0000, 0};

    @(negedge clk);
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_data", deq_data, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_bram_addr", bram_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_enq_ready", enq_ready, 1);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_enq) begin
        do_enq(vecs[i].data, lat, rl);
        check($sformatf("v%0d_head", i), deq_data, vecs[i].exp_val);
        check($sformatf("v%0d_enq_lat", i), lat, 2 * (vecs[i].exp_cnt - 1) + 1);
      end else begin
        do_deq(v, lat);
        check($sformatf("v%0d_deq", i), v, vecs[i].exp_val);
        check($sformatf("v%0d_deq_lat", i), lat,
              (vecs[i].exp_cnt == 0) ? 0 : 2 * vecs[i].exp_cnt);
      end
      check($sformatf("v%0d_count", i), count, vecs[i].exp_cnt);
      check($sformatf("v%0d_empty", i), empty, vecs[i].exp_cnt == 0);
    end

    // latency and BRAM write traces
    do_reset();
    do_enq(32'd30, lat, rl);
    do_enq(32'd20, lat, rl);
    do_enq(32'd10, lat, rl);
    tr.delete();
    tr_en = 1'b1;
    do_deq(v, lat);
    tr_en = 1'b0;
    check("t3_deq_val", v, 30);
    check("t3_deq_lat", lat, 4);
    check("t3_deq_tr_len", tr.size(), 2);
    check_tr(0, 0, 32'd20);
    check_tr(1, 1, 32'd10);
    tr.delete();
    tr_en = 1'b1;
    do_enq(32'd15, lat, rl);
    tr_en = 1'b0;
    check("t3_swap_lat", lat, 5);
    check("t3_swap_tr_len", tr.size(), 2);
    check_tr(0, 1, 32'd15);
    check_tr(1, 2, 32'd10);
    tr.delete();
    tr_en = 1'b1;
    do_enq(32'd0, lat, rl);
    tr_en = 1'b0;
    check("t3_enq_busy_cycles", lat, 7);
    check("t3_enq_rdy_low", rl, 7);
    check("t3_enq_tr_len", tr.size(), 1);
    check_tr(0, 3, 32'd0);
    check("t3_count", count, 4);

    // simultaneous enqueue and dequeue: dequeue wins
    do_reset();
    do_enq(32'd7, lat, rl);
    do_enq(32'd3, lat, rl);
    enq_valid = 1'b1;
    enq_data  = 32'd5;
    deq_ready = 1'b1;
    #1;
    check("t4_enq_ready_blocked", enq_ready, 0);
    check("t4_deq_data", deq_data, 7);
    @(negedge clk);
    deq_ready = 1'b0;
    check("t4_busy", busy, 1);
    w = 0;
    while (!enq_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("t4_shift_cycles", w, 2);
    check("t4_count_mid", count, 1);
    @(negedge clk);
    enq_valid = 1'b0;
    wait_idle(lat, rl);
    check("t4_enq_lat", lat, 3);
    check("t4_count", count, 2);
    do_deq(v, lat);
    check("t4_deq1", v, 5);
    do_deq(v, lat);
    check("t4_deq2", v, 3);

    // full queue with a held enqueue
    do_reset();
    foreach (vecs[i]) if (i < 8) do_enq(32'(8 - i), lat, rl);
    check("t2_full", full, 1);
    check("t2_count", count, 8);
    check("t2_enq_ready", enq_ready, 0);
    enq_valid = 1'b1;
    enq_data  = 32'd99;
    repeat (4) @(negedge clk);
    check("t2_held_count", count, 8);
    check("t2_held_busy", busy, 0);
    deq_ready = 1'b1;
    v = deq_data;
    @(negedge clk);
    deq_ready = 1'b0;
    check("t2_deq_val", v, 8);
    w = 0;
    while (!enq_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("t2_shift_cycles", w, 14);
    @(negedge clk);
    enq_valid = 1'b0;
    wait_idle(lat, rl);
    check("t2_enq_lat", lat, 15);
    check("t2_full_again", full, 1);
    do_deq(v, lat);
    check("t2_deq_99", v, 99);
    do_deq(v, lat);
    check("t2_deq_next", v, 7);

    // reset in the middle of an insert walk
    do_reset();
    for (int i = 1; i <= 5; i++) do_enq(32'(10 * i), lat, rl);
    check("t6_count5", count, 5);
    enq_valid = 1'b1;
    enq_data  = 32'd25;
    @(negedge clk);
    enq_valid = 1'b0;
    @(negedge clk);
    check("t6_busy_cmp", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_deq_valid", deq_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_bram_we", bram_we, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_enq(32'd42, lat, rl);
    do_deq(v, lat);
    check("t6_deq_42", v, 42);
    check("t6_empty_end", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
